// File: rtl/wb_select_pipe.sv
// ---------------------------------------------------------------------------
// wb_select_pipe
//   Writeback-source selector for the register-file write port. Picks one of
//   NSRC external sources or a built-in constant, tags it with the
//   destination register, and holds it in a registered output stage backed
//   by a single skid entry, so the register file can stall without loss.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   src_flat           NSRC sources, source i at [i*W +: W]
//   sel, dest_in       source select and destination register of a request
//   in_valid/in_ready  request handshake
//   out_data/out_dest  selected value and its destination
//   out_valid/out_ready  writeback handshake
//   sel_err/err_sel    sticky illegal-select flag and first offending select
//   err_clr            clears sel_err/err_sel (a same-cycle set wins)
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. in_ready depends only on registered state (skid occupancy).
// The payload is held stable while out_valid is high and out_ready is low.
// ---------------------------------------------------------------------------
module wb_select_pipe #(
  parameter int              W         = 32,
  parameter int              NSRC      = 10,
  parameter int              SELW      = 4,
  parameter int              REGW      = 5,
  parameter logic [W-1:0]    CONST_VAL = 32'd227,
  parameter bit              ZERO_DROP = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC*W-1:0] src_flat,
  input  logic [SELW-1:0]   sel,
  input  logic [REGW-1:0]   dest_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic [REGW-1:0]   out_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sel_err,
  output logic [SELW-1:0]   err_sel,
  input  logic              err_clr
);

  localparam logic [SELW-1:0] SEL_CONST = SELW'(NSRC);

  logic            skid_valid;
  logic [W-1:0]    skid_data;
  logic [REGW-1:0] skid_dest;

  logic [W-1:0]    sel_data;
  logic            sel_illegal;
  logic            accept;
  logic            fwd;
  logic            slot_free;

  // Source decode: external sources below NSRC, the constant at NSRC,
  // anything above is illegal.
  always_comb begin
    sel_data    = '0;
    sel_illegal = 1'b0;
    if (sel == SEL_CONST) begin
      sel_data = CONST_VAL;
    end else if (sel > SEL_CONST) begin
      sel_illegal = 1'b1;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (sel == SELW'(i)) sel_data = src_flat[i*W +: W];
      end
    end
  end

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  // Illegal selects and (optionally) writes to register 0 are swallowed
  // at the input and never take a storage slot.
  assign fwd       = accept & ~sel_illegal & ~(ZERO_DROP && (dest_in == '0));
  assign slot_free = ~out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dest   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_dest  <= '0;
    end else if (slot_free) begin
      if (skid_valid) begin
        // Older skid entry moves up first to keep FIFO order.
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_dest   <= skid_dest;
        skid_valid <= fwd;
        if (fwd) begin
          skid_data <= sel_data;
          skid_dest <= dest_in;
        end
      end else begin
        out_valid <= fwd;
        if (fwd) begin
          out_data <= sel_data;
          out_dest <= dest_in;
        end
      end
    end else if (fwd) begin
      skid_valid <= 1'b1;
      skid_data  <= sel_data;
      skid_dest  <= dest_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
      err_sel <= '0;
    end else if (accept && sel_illegal) begin
      sel_err <= 1'b1;
      // A clear in the same cycle makes this the first error since the clear.
      if (!sel_err || err_clr) err_sel <= sel;
    end else if (err_clr) begin
      sel_err <= 1'b0;
      err_sel <= '0;
    end
  end

endmodule

// File: tb/tb_wb_select_pipe.sv
module tb_wb_select_pipe;

  localparam int W    = 32;
  localparam int NSRC = 10;
  localparam int SELW = 4;
  localparam int REGW = 5;
  localparam logic [W-1:0] CVAL = 32'd227;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [W-1:0]      src [NSRC];
  logic [NSRC*W-1:0] src_flat;
  logic [SELW-1:0]   sel;
  logic [REGW-1:0]   dest_in;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      out_data;
  logic [REGW-1:0]   out_dest;
  logic              out_valid;
  logic              out_ready;
  logic              sel_err;
  logic [SELW-1:0]   err_sel;
  logic              err_clr;

  always_comb begin
    for (int i = 0; i < NSRC; i++) src_flat[i*W +: W] = src[i];
  end

  wb_select_pipe dut (
    .clk(clk), .reset(reset), .src_flat(src_flat), .sel(sel), .dest_in(dest_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_dest(out_dest),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err), .err_sel(err_sel),
    .err_clr(err_clr)
  );

  // scoreboard / reference model: FIFO of pending writes {dest, data},
  // capacity 2 (output stage plus skid), plus sticky error state
  logic [W+REGW-1:0] exp_q[$];
  logic              m_err;
  logic [SELW-1:0]   m_err_sel;
  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: check outputs against the model, then advance the model
  task automatic cycle();
    logic acc, fwd, cons, ill;
    logic [W-1:0] d;
    @(negedge clk);
    if (!reset) begin
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(exp_q[0][W-1:0]));
        chk("out_dest", 64'(out_dest), 64'(exp_q[0][W+REGW-1:W]));
      end
      chk("sel_err", 64'(sel_err), 64'(m_err));
      chk("err_sel", 64'(err_sel), 64'(m_err_sel));
    end
    acc  = in_valid && (exp_q.size() < 2);
    ill  = (int'(sel) > NSRC);
    d    = (int'(sel) < NSRC) ? src[sel] : CVAL;
    fwd  = acc && !ill && (dest_in != 0);
    cons = (exp_q.size() > 0) && out_ready;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_err = 1'b0;
      m_err_sel = '0;
    end else begin
      if (cons) void'(exp_q.pop_front());
      if (fwd) exp_q.push_back({dest_in, d});
      if (acc && ill) begin
        if (!m_err || err_clr) m_err_sel = sel;
        m_err = 1'b1;
      end else if (err_clr) begin
        m_err = 1'b0;
        m_err_sel = '0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input int s, input int dst, input logic rdy);
    in_valid  = v;
    sel       = SELW'(s);
    dest_in   = REGW'(dst);
    out_ready = rdy;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_err = 1'b0; m_err_sel = '0;
    for (int i = 0; i < NSRC; i++) src[i] = 32'h1000 + i;
    reset = 1'b1; err_clr = 1'b0;
    drive(1'b0, 0, 0, 1'b1);
    cycle(); cycle();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_dest", 64'(out_dest), 64'd0);
    chk("rst_sel_err", 64'(sel_err), 64'd0);
    chk("rst_err_sel", 64'(err_sel), 64'd0);

    // all sources back-to-back
    for (int i = 0; i < NSRC; i++) begin
      drive(1'b1, i, 5, 1'b1);
      cycle();
      chk("t1_data", 64'(out_data), 64'(32'h1000 + i));
      chk("t1_dest", 64'(out_dest), 64'd5);
    end
    // constant source
    drive(1'b1, 10, 3, 1'b1);
    cycle();
    chk("t2_const", 64'(out_data), 64'd227);
    chk("t2_dest", 64'(out_dest), 64'd3);
    // illegal selects
    drive(1'b1, 12, 4, 1'b1);
    cycle();
    drive(1'b0, 0, 0, 1'b1);
    cycle();
    chk("t3_valid", 64'(out_valid), 64'd0);
    chk("t3_err", 64'(sel_err), 64'd1);
    chk("t3_errsel", 64'(err_sel), 64'd12);
    drive(1'b1, 13, 4, 1'b1);
    cycle();
    chk("t3_errsel_keep", 64'(err_sel), 64'd12);
    drive(1'b0, 0, 0, 1'b1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    chk("t3_clr_err", 64'(sel_err), 64'd0);
    chk("t3_clr_sel", 64'(err_sel), 64'd0);
    // writes to register 0 are dropped
    drive(1'b1, 0, 0, 1'b1);
    cycle();
    chk("t4_ready", 64'(in_ready), 64'd1);
    chk("t4_valid", 64'(out_valid), 64'd0);
    chk("t4_err", 64'(sel_err), 64'd0);
    // stall: A then B fill output and skid
    drive(1'b1, 1, 7, 1'b0);
    cycle();
    drive(1'b1, 2, 8, 1'b0);
    cycle();
    drive(1'b0, 0, 0, 1'b0);
    chk("t5_full", 64'(in_ready), 64'd0);
    chk("t5_hold_a", 64'(out_data), 64'h1001);
    src[1] = 32'hdead_beef;            // later source change must not leak in
    cycle();
    chk("t5_still_a", 64'(out_data), 64'h1001);
    out_ready = 1'b1;
    cycle();
    chk("t5_b", 64'(out_data), 64'h1002);
    chk("t5_b_dest", 64'(out_dest), 64'd8);
    chk("t5_ready", 64'(in_ready), 64'd1);
    cycle();
    chk("t5_drained", 64'(out_valid), 64'd0);
    // reset while full
    drive(1'b1, 3, 9, 1'b0);
    cycle();
    drive(1'b1, 4, 10, 1'b0);
    cycle();
    reset = 1'b1;
    drive(1'b0, 0, 0, 1'b1);
    cycle();
    reset = 1'b0;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);
    cycle(); cycle();
    chk("t6_no_stale", 64'(out_valid), 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NSRC; i++) src[i] = $urandom;
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31)),
            $urandom_range(0, 2) != 0);
      err_clr = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0; err_clr = 1'b0;
    drive(1'b0, 0, 0, 1'b1);
    cycle(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
